// File: rtl/noc_turn_arbiter_pkg.sv
// Shared port indices, turn encodings, legal-owner masks and rotation helpers for the turn arbiter.
package noc_turn_arbiter_pkg;

  typedef enum logic [2:0] {
    P_L = 3'd0,
    P_W = 3'd1,
    P_E = 3'd2,
    P_S = 3'd3,
    P_N = 3'd4
  } port_e;

  localparam logic [4:0] TURN_N = 5'b10000;
  localparam logic [4:0] TURN_S = 5'b01000;
  localparam logic [4:0] TURN_E = 5'b00100;
  localparam logic [4:0] TURN_W = 5'b00010;
  localparam logic [4:0] TURN_L = 5'b00001;

  // Indexed by output port; bit i set means input i may own that output under Y-first routing.
  localparam logic [4:0][4:0] LEGAL_MASK = {
    TURN_S | TURN_L,                   // N out
    TURN_N | TURN_L,                   // S out
    TURN_N | TURN_S | TURN_W | TURN_L, // E out
    TURN_N | TURN_S | TURN_E | TURN_L, // W out
    TURN_N | TURN_S | TURN_E | TURN_W  // L out
  };

  localparam logic [4:0][4:0] RESET_TURN = {TURN_S, TURN_N, TURN_N, TURN_N, TURN_N};

  function automatic logic [4:0] rot_next(input logic [4:0] t);
    return {t[0], t[4:1]};
  endfunction

  function automatic logic [4:0] next_legal(input logic [4:0] t, input logic [4:0] mask);
    logic [4:0] c;
    logic       done;
    c          = t;
    done       = 1'b0;
    next_legal = t;
    for (int i = 0; i < 4; i++) begin
      c = rot_next(c);
      if (!done && ((c & mask) != 5'b0)) begin
        next_legal = c;
        done       = 1'b1;
      end
    end
  endfunction

  // Returns {found, target}: first candidate after t in rotation order.
  function automatic logic [5:0] next_req(input logic [4:0] t, input logic [4:0] cand);
    logic [4:0] c;
    next_req = 6'b0;
    c        = t;
    for (int i = 0; i < 4; i++) begin
      c = rot_next(c);
      if (!next_req[5] && ((c & cand) != 5'b0)) next_req = {1'b1, c};
    end
  endfunction

endpackage

// File: rtl/noc_turn_arbiter_if.sv
// Router-side signal bundle for the turn arbiter: per-port flit headers, valids, full/enable, turns.
interface noc_turn_arbiter_if;
  logic [7:0] N_data_i, S_data_i, E_data_i, W_data_i, L_data_i;
  logic       N_valid_i, S_valid_i, E_valid_i, W_valid_i, L_valid_i;
  logic       N_port_full, S_port_full, E_port_full, W_port_full, L_port_full;
  logic       N_port_enable, S_port_enable, E_port_enable, W_port_enable, L_port_enable;
  logic [4:0] N_turn, S_turn, E_turn, W_turn, L_turn;

  modport master (
    output N_data_i, S_data_i, E_data_i, W_data_i, L_data_i,
    output N_valid_i, S_valid_i, E_valid_i, W_valid_i, L_valid_i,
    output N_port_full, S_port_full, E_port_full, W_port_full, L_port_full,
    output N_port_enable, S_port_enable, E_port_enable, W_port_enable, L_port_enable,
    input  N_turn, S_turn, E_turn, W_turn, L_turn
  );

  modport slave (
    input  N_data_i, S_data_i, E_data_i, W_data_i, L_data_i,
    input  N_valid_i, S_valid_i, E_valid_i, W_valid_i, L_valid_i,
    input  N_port_full, S_port_full, E_port_full, W_port_full, L_port_full,
    input  N_port_enable, S_port_enable, E_port_enable, W_port_enable, L_port_enable,
    output N_turn, S_turn, E_turn, W_turn, L_turn
  );
endinterface

// File: rtl/noc_turn_arbiter_xy_decode.sv
// Y-first XY route decode of one input's head flit into a one-hot requested-output vector.
module noc_turn_arbiter_xy_decode
  import noc_turn_arbiter_pkg::*;
#(
  parameter logic [3:0] XCOORD = 4'd0,
  parameter logic [3:0] YCOORD = 4'd0
) (
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic [4:0] req_o
);

  logic [3:0] dest_x, dest_y;

  assign dest_x = data_i[7:4];
  assign dest_y = data_i[3:0];

  always_comb begin
    req_o = 5'b0;
    if (valid_i) begin
      if (dest_y > YCOORD)      req_o = TURN_S;
      else if (dest_y < YCOORD) req_o = TURN_N;
      else if (dest_x > XCOORD) req_o = TURN_E;
      else if (dest_x < XCOORD) req_o = TURN_W;
      else                      req_o = TURN_L;
    end
  end

endmodule

// File: rtl/noc_turn_arbiter.sv
// Per-router round-robin owner of the five output turn vectors.
// Optional TURN_SKIP_EN: advance directly to the next requesting legal input.
module noc_turn_arbiter
  import noc_turn_arbiter_pkg::*;
#(
  parameter logic [3:0] XCOORD = 4'd0,
  parameter logic [3:0] YCOORD = 4'd0
) (
  input logic               clk,
  input logic               rst,
  noc_turn_arbiter_if.slave bus
);

  logic [4:0][7:0] data;
  logic [4:0]      valid, full, enable;
  logic [4:0][4:0] req;      // req[input] = requested outputs
  logic [4:0][4:0] out_req;  // out_req[output] = requesting inputs
  logic [4:0][4:0] turn;

  assign data   = {bus.N_data_i, bus.S_data_i, bus.E_data_i, bus.W_data_i, bus.L_data_i};
  assign valid  = {bus.N_valid_i, bus.S_valid_i, bus.E_valid_i, bus.W_valid_i, bus.L_valid_i};
  assign full   = {bus.N_port_full, bus.S_port_full, bus.E_port_full, bus.W_port_full,
                   bus.L_port_full};
  assign enable = {bus.N_port_enable, bus.S_port_enable, bus.E_port_enable, bus.W_port_enable,
                   bus.L_port_enable};

  for (genvar i = 0; i < 5; i++) begin : g_dec
    noc_turn_arbiter_xy_decode #(
      .XCOORD(XCOORD),
      .YCOORD(YCOORD)
    ) u_dec (
      .data_i (data[i]),
      .valid_i(valid[i]),
      .req_o  (req[i])
    );
  end

  always_comb begin
    out_req = '0;
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < 5; i++) out_req[o][i] = req[i][o];
    end
  end

  for (genvar o = 0; o < 5; o++) begin : g_turn
    localparam logic [4:0] Mask = LEGAL_MASK[o];

    logic [4:0] turn_q, turn_d;
    logic       owner_req;
    logic [4:0] cand;

    assign owner_req = |(turn_q & out_req[o] & Mask);
    assign cand      = out_req[o] & Mask & ~turn_q;

`ifdef TURN_SKIP_EN
    logic [5:0] skip;
    assign skip = next_req(turn_q, cand);

    always_comb begin
      turn_d = turn_q;
      if (enable[o])                              turn_d = skip[5] ? skip[4:0]
                                                                   : next_legal(turn_q, Mask);
      else if (owner_req && (full[o] || !enable[o])) turn_d = turn_q;
      else if (skip[5])                           turn_d = skip[4:0];
    end
`else
    logic unused_cand;
    assign unused_cand = ^cand;

    always_comb begin
      turn_d = turn_q;
      if (enable[o])                                 turn_d = next_legal(turn_q, Mask);
      else if (owner_req && (full[o] || !enable[o])) turn_d = turn_q;
      else                                           turn_d = next_legal(turn_q, Mask);
    end
`endif

    always_ff @(posedge clk) begin
      if (rst) turn_q <= RESET_TURN[o];
      else     turn_q <= turn_d;
    end

    assign turn[o] = turn_q;
  end

  assign bus.N_turn = turn[P_N];
  assign bus.S_turn = turn[P_S];
  assign bus.E_turn = turn[P_E];
  assign bus.W_turn = turn[P_W];
  assign bus.L_turn = turn[P_L];

endmodule
